// File: rtl/dma_req_arbiter.sv
// Purpose : arbitrate I-cache / D-cache line misses onto the dma refill and write-back
//           request ports; a dirty D-cache victim is written back before its refill.
// Latency : req -> dma *_happen 1 cycle; dma *_done -> next phase / requester done 1 cycle.
// Backpressure: one transaction in flight; requests are levels held until *_miss_done,
//           dma request lines stay stable until the matching dma *_done pulse.
// Ports   : cpu_clk/cpu_rst (sync, active-high); icache_miss_* and dcache_miss_* requester
//           sides (req/addr/burst_len in, done pulse out); dma_page_fault_* and
//           dma_write_back_* request sides (happen/addr/burst_len out, done in);
//           arb_busy (not idle) and arb_owner (0 = I-cache, 1 = D-cache).
module dma_req_arbiter #(
    parameter int ADDR_WIDTH      = 32,
    parameter int BURST_LEN_WIDTH = 8
) (
    input  logic                       cpu_clk,
    input  logic                       cpu_rst,
    input  logic                       icache_miss_req,
    input  logic [ADDR_WIDTH-1:0]      icache_miss_addr,
    input  logic [BURST_LEN_WIDTH-1:0] icache_miss_burst_len,
    output logic                       icache_miss_done,
    input  logic                       dcache_miss_req,
    input  logic [ADDR_WIDTH-1:0]      dcache_miss_addr,
    input  logic [BURST_LEN_WIDTH-1:0] dcache_miss_burst_len,
    input  logic                       dcache_victim_dirty,
    input  logic [ADDR_WIDTH-1:0]      dcache_victim_addr,
    output logic                       dcache_miss_done,
    output logic                       dma_page_fault_happen,
    output logic [ADDR_WIDTH-1:0]      dma_page_fault_addr,
    output logic [BURST_LEN_WIDTH-1:0] dma_page_fault_burst_len,
    input  logic                       dma_page_fault_done,
    output logic                       dma_write_back_happen,
    output logic [ADDR_WIDTH-1:0]      dma_write_back_addr,
    output logic [BURST_LEN_WIDTH-1:0] dma_write_back_burst_len,
    input  logic                       dma_write_back_done,
    output logic                       arb_busy,
    output logic                       arb_owner
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WB   = 2'd1,
        S_RD   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t                     state_q, state_nxt;
    logic                       owner_q, owner_nxt;
    logic                       prio_dcache_q, prio_dcache_nxt;
    logic [ADDR_WIDTH-1:0]      miss_addr_q, miss_addr_nxt;
    logic [ADDR_WIDTH-1:0]      victim_addr_q, victim_addr_nxt;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_nxt;
    logic                       pf_happen_q, pf_happen_nxt;
    logic                       wb_happen_q, wb_happen_nxt;
    logic                       idone_q, idone_nxt;
    logic                       ddone_q, ddone_nxt;
    logic                       grant_dcache;

    always_comb begin
        state_nxt       = state_q;
        owner_nxt       = owner_q;
        prio_dcache_nxt = prio_dcache_q;
        miss_addr_nxt   = miss_addr_q;
        victim_addr_nxt = victim_addr_q;
        len_nxt         = len_q;
        pf_happen_nxt   = 1'b0;
        wb_happen_nxt   = 1'b0;
        idone_nxt       = 1'b0;
        ddone_nxt       = 1'b0;
        grant_dcache    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (icache_miss_req || dcache_miss_req) begin
                    // D-cache wins when alone, or when both ask and the pointer favours it.
                    grant_dcache    = dcache_miss_req && (!icache_miss_req || prio_dcache_q);
                    owner_nxt       = grant_dcache;
                    prio_dcache_nxt = !grant_dcache;
                    if (grant_dcache) begin
                        miss_addr_nxt   = dcache_miss_addr;
                        victim_addr_nxt = dcache_victim_addr;
                        len_nxt         = dcache_miss_burst_len;
                    end else begin
                        miss_addr_nxt   = icache_miss_addr;
                        len_nxt         = icache_miss_burst_len;
                    end
                    if (grant_dcache && dcache_victim_dirty) begin
                        state_nxt     = S_WB;
                        wb_happen_nxt = 1'b1;
                    end else begin
                        state_nxt     = S_RD;
                        pf_happen_nxt = 1'b1;
                    end
                end
            end
            S_WB: begin
                wb_happen_nxt = 1'b1;
                if (dma_write_back_done) begin
                    // write-back drops and refill rises on the same edge: never both high
                    wb_happen_nxt = 1'b0;
                    pf_happen_nxt = 1'b1;
                    state_nxt     = S_RD;
                end
            end
            S_RD: begin
                pf_happen_nxt = 1'b1;
                if (dma_page_fault_done) begin
                    pf_happen_nxt = 1'b0;
                    idone_nxt     = !owner_q;
                    ddone_nxt     = owner_q;
                    state_nxt     = S_RESP;
                end
            end
            S_RESP: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            state_q       <= S_IDLE;
            owner_q       <= 1'b0;
            prio_dcache_q <= 1'b1;
            miss_addr_q   <= '0;
            victim_addr_q <= '0;
            len_q         <= '0;
            pf_happen_q   <= 1'b0;
            wb_happen_q   <= 1'b0;
            idone_q       <= 1'b0;
            ddone_q       <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            owner_q       <= owner_nxt;
            prio_dcache_q <= prio_dcache_nxt;
            miss_addr_q   <= miss_addr_nxt;
            victim_addr_q <= victim_addr_nxt;
            len_q         <= len_nxt;
            pf_happen_q   <= pf_happen_nxt;
            wb_happen_q   <= wb_happen_nxt;
            idone_q       <= idone_nxt;
            ddone_q       <= ddone_nxt;
        end
    end

    assign dma_page_fault_happen    = pf_happen_q;
    assign dma_page_fault_addr      = miss_addr_q;
    assign dma_page_fault_burst_len = len_q;
    assign dma_write_back_happen    = wb_happen_q;
    assign dma_write_back_addr      = victim_addr_q;
    assign dma_write_back_burst_len = len_q;
    assign icache_miss_done         = idone_q;
    assign dcache_miss_done         = ddone_q;
    assign arb_busy                 = (state_q != S_IDLE);
    assign arb_owner                = owner_q;

endmodule
